rs_id_allocator: RTL and testbench
==================================

# rs_id_allocator

Allocates reservation-station IDs (tags) to the dispatcher and reclaims them when results are written back. It sits between the dispatcher and the register files. Each tag it hands out names the in-flight producer of a GPR/SPR/CR entry. Tags return to the pool from the GPR write-back bus and the CR/SPR write-back bus. Tag 0 is reserved as "no pending producer" and is never allocated.

## Interface
- RS_ID_WIDTH, 5, tag width; tag space 0..2**RS_ID_WIDTH-1, allocatable tags 1..2**RS_ID_WIDTH-1
- FREE_PORTS, 2, number of independent tag-return ports (port 0 = GPR write-back, port 1 = CR/SPR write-back)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  dispatcher takes alloc_id this cycle
- alloc_ready  out  1  at least one tag free and no flush in progress
- alloc_id  out  RS_ID_WIDTH  lowest-numbered free tag; 0 when alloc_ready=0
- free_valid[0:FREE_PORTS-1]  in  1 each  return free_id[i] this cycle
- free_id[0:FREE_PORTS-1]  in  RS_ID_WIDTH each  tag being returned
- flush  in  1  return every tag to the pool
- in_flight  out  RS_ID_WIDTH  number of busy tags (registered)
- double_free_error  out  1  one-cycle pulse: illegal free seen in previous cycle

## Operation
- State: busy bitmap busy[1:2**RS_ID_WIDTH-1]. Bit 0 does not exist and always reads free.
- State: in_flight counter; double_free_error register.
- Reset (rst=0, asynchronous): busy all 0, in_flight=0, double_free_error=0. Outputs immediately read alloc_ready=1, alloc_id=1.
- alloc_ready and alloc_id are combinational from the registered bitmap.
  - alloc_ready = (any busy bit 0) and !flush.
  - alloc_id comes from a priority encoder (lowest free index).
- Allocation fires when alloc_valid && alloc_ready. It sets busy[alloc_id] at the next edge.
- alloc_valid while alloc_ready=0: no effect, no error.
- Free on port i fires when free_valid[i], and clears busy[free_id[i]] at the next edge.
- Illegal frees are ignored and set double_free_error at the next edge:
  - free_id[i] whose busy bit is already 0 in the current registered state;
  - this includes a tag being allocated in the same cycle, since it is not yet busy.
- Two ports freeing the same busy tag in one cycle: the tag is cleared once and double_free_error is set.
- free_id=0: ignored silently, no error.
- Allocation and legal frees of different tags in the same cycle all take effect.
- in_flight next = in_flight + (alloc fired) − (number of distinct legal frees).
- flush: at the next edge busy clears to all 0 and in_flight becomes 0. Concurrent alloc is blocked (alloc_ready=0) and concurrent frees are discarded without error.
- in_flight never exceeds 2**RS_ID_WIDTH-1, so it fits in RS_ID_WIDTH bits.

## Timing
- Allocation is zero-latency: a tag is presented in the same cycle as alloc_ready and is consumed on the handshake edge.
- Freed tag is visible to allocation one cycle after free_valid. There is no same-cycle free-to-alloc bypass.
- Full condition: when the last free tag is allocated at edge N, alloc_ready=0 from edge N. A legal free at cycle N+k makes alloc_ready=1 from edge N+k+1.
- Back-to-back allocation at one tag per cycle is sustained while tags remain.
- double_free_error is high for exactly one cycle after each offending cycle.
- in_flight updates on the same edge as the bitmap.
- rst asserted mid-operation: the state is cleared asynchronously. The first allocation after release returns tag 1.

## Test plan
- Reset then 31 consecutive allocations with alloc_valid=1 → alloc_id 1,2,…,31 on successive cycles. On the 32nd cycle alloc_ready=0, alloc_id=0 and in_flight=31.
- From full, free tag 17 on port 0 → next cycle alloc_ready=1, alloc_id=17. Allocating it restores in_flight=31.
- Same cycle: allocate tag 5, port 0 frees busy tag 2, port 1 frees busy tag 3 → next cycle busy{5} set, {2,3} clear, in_flight decreases by 1, next alloc_id=2.
- Free a tag that is not busy (tag 9), and separately free tag 4 on both ports in one cycle → double_free_error pulses one cycle each time. Busy state is otherwise unchanged except tag 4 cleared once; in_flight decreases by 1 only.
- With 12 tags busy, assert flush while alloc_valid=1 and a free is pending → alloc_ready=0 during flush, no tag issued, no error. Next cycle in_flight=0 and alloc_id=1.
- Drive rst=0 asynchronously mid-cycle with 7 tags busy → outputs go to reset values without a clock edge. After release the first alloc_id=1.

Source files
------------

// File: rtl/rs_id_allocator.sv
// Reservation-station tag allocator: hands out the lowest free tag (1..2**W-1)
// and reclaims tags from the write-back ports. Tag 0 means "no pending producer".
module rs_id_allocator #(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned FREE_PORTS  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    alloc_valid,
  output logic                                    alloc_ready,
  output logic [RS_ID_WIDTH-1:0]                  alloc_id,
  input  logic [FREE_PORTS-1:0]                   free_valid,
  input  logic [FREE_PORTS-1:0][RS_ID_WIDTH-1:0]  free_id,
  input  logic                                    flush,
  output logic [RS_ID_WIDTH-1:0]                  in_flight,
  output logic                                    double_free_error
);

  localparam int unsigned NUM_IDS = 1 << RS_ID_WIDTH;

  logic [NUM_IDS-1:1]     r_busy;
  logic [RS_ID_WIDTH-1:0] r_in_flight;
  logic                   r_dfe;

  logic [NUM_IDS-1:0]     w_busy_full;
  logic                   w_any_free;
  logic [RS_ID_WIDTH-1:0] w_low_id;
  logic                   w_alloc_fire;
  logic [FREE_PORTS-1:0]  w_dup;
  logic [FREE_PORTS-1:0]  w_legal;
  logic                   w_err;
  logic [RS_ID_WIDTH-1:0] w_free_cnt;
  logic [NUM_IDS-1:1]     w_busy_nxt;
  logic [RS_ID_WIDTH-1:0] w_in_flight_nxt;

  // Tag 0 never exists in the bitmap, so it reads as not busy.
  assign w_busy_full = {r_busy, 1'b0};

  // Lowest-index free tag; scanning downward lets the smallest index win.
  always_comb begin
    w_any_free = 1'b0;
    w_low_id   = '0;
    for (int i = int'(NUM_IDS) - 1; i >= 1; i--) begin
      if (!r_busy[i]) begin
        w_any_free = 1'b1;
        w_low_id   = RS_ID_WIDTH'(i);
      end
    end
  end

  assign alloc_ready  = w_any_free && !flush;
  assign alloc_id     = alloc_ready ? w_low_id : '0;
  assign w_alloc_fire = alloc_valid && alloc_ready;

  // A port repeating a tag already presented on a lower port is a duplicate.
  always_comb begin
    w_dup = '0;
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      for (int q = 0; q < p; q++) begin
        if (free_valid[q] && (free_id[q] == free_id[p])) begin
          w_dup[p] = 1'b1;
        end
      end
    end
  end

  // Classify each return as legal or illegal; flush discards returns silently.
  always_comb begin
    w_legal    = '0;
    w_err      = 1'b0;
    w_free_cnt = '0;
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      if (free_valid[p] && (free_id[p] != '0) && !flush) begin
        if (w_busy_full[free_id[p]] && !w_dup[p]) begin
          w_legal[p] = 1'b1;
          w_free_cnt = w_free_cnt + RS_ID_WIDTH'(1);
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // Next bitmap: the allocated tag was free, so it never collides with a legal return.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 1; k < int'(NUM_IDS); k++) begin
      if (w_alloc_fire && (w_low_id == RS_ID_WIDTH'(k))) begin
        w_busy_nxt[k] = 1'b1;
      end
      for (int p = 0; p < int'(FREE_PORTS); p++) begin
        if (w_legal[p] && (free_id[p] == RS_ID_WIDTH'(k))) begin
          w_busy_nxt[k] = 1'b0;
        end
      end
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  always_comb begin
    w_in_flight_nxt = r_in_flight + RS_ID_WIDTH'(w_alloc_fire) - w_free_cnt;
    if (flush) begin
      w_in_flight_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= '0;
      r_in_flight <= '0;
      r_dfe       <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_in_flight <= w_in_flight_nxt;
      r_dfe       <= w_err;
    end
  end

  assign in_flight         = r_in_flight;
  assign double_free_error = r_dfe;

endmodule

// File: tb/tb_rs_id_allocator.sv
// Self-checking bench for rs_id_allocator: directed table, hand sequences for
// flush and asynchronous reset, then random traffic against a tag-set model.
module tb_rs_id_allocator;

  localparam int unsigned W = 5;
  localparam int NT = 32;

  logic               clk;
  logic               rst;
  logic               alloc_valid;
  logic               alloc_ready;
  logic [W-1:0]       alloc_id;
  logic [1:0]         free_valid;
  logic [1:0][W-1:0]  free_id;
  logic               flush;
  logic [W-1:0]       in_flight;
  logic               double_free_error;

  int n_checks;
  int n_errors;

  // Reference model: set of busy tags plus the pending error flag.
  bit m_busy[NT];
  bit m_err;

  typedef struct {
    logic         av;
    logic [1:0]   fv;
    logic [W-1:0] id0;
    logic [W-1:0] id1;
    logic         fl;
    logic         exp_ready;
    logic [W-1:0] exp_id;
    logic [W-1:0] exp_if;
    logic         exp_err;
  } vec_t;

  vec_t tbl[18];

  rs_id_allocator #(.RS_ID_WIDTH(W), .FREE_PORTS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_valid       (alloc_valid),
    .alloc_ready       (alloc_ready),
    .alloc_id          (alloc_id),
    .free_valid        (free_valid),
    .free_id           (free_id),
    .flush             (flush),
    .in_flight         (in_flight),
    .double_free_error (double_free_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_lowest();
    for (int t = 1; t < NT; t++) if (!m_busy[t]) return t;
    return 0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int t = 1; t < NT; t++) if (m_busy[t]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < NT; t++) m_busy[t] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic drive(input logic av, input logic [1:0] fv, input logic [W-1:0] i0,
                       input logic [W-1:0] i1, input logic fl);
    alloc_valid = av;
    free_valid  = fv;
    free_id[0]  = i0;
    free_id[1]  = i1;
    flush       = fl;
  endtask

  task automatic check_model();
    int lo;
    bit rdy;
    lo  = m_lowest();
    rdy = (lo != 0) && !flush;
    chk("model_ready", int'(alloc_ready), int'(rdy));
    chk("model_id", int'(alloc_id), rdy ? lo : 0);
    chk("model_in_flight", int'(in_flight), m_count());
    chk("model_dfe", int'(double_free_error), int'(m_err));
  endtask

  // Apply the allocation rules to the currently driven inputs.
  task automatic model_step();
    int  lo;
    bit  fire;
    bit  err;
    int  freed[$];
    int  id;
    bit  seen;
    lo   = m_lowest();
    fire = alloc_valid && (lo != 0) && !flush;
    err  = 1'b0;
    if (flush) begin
      for (int t = 0; t < NT; t++) m_busy[t] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (free_valid[p]) begin
          id = int'(free_id[p]);
          if (id != 0) begin
            seen = 1'b0;
            foreach (freed[k]) if (freed[k] == id) seen = 1'b1;
            if (!m_busy[id] || seen) err = 1'b1;
            else freed.push_back(id);
          end
        end
      end
      foreach (freed[k]) m_busy[freed[k]] = 1'b0;
      if (fire) m_busy[lo] = 1'b1;
    end
    m_err = err;
  endtask

  task automatic tick();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_reset();
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b0);

    // Directed table, applied from the full state.
    tbl[0]  = '{1'b1, 2'b01, 5'd17, 5'd0, 1'b0, 1'b0, 5'd0,  5'd31, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd17, 5'd30, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  5'd31, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 5'd5,  5'd0, 1'b0, 1'b0, 5'd0,  5'd31, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 5'd2,  5'd3, 1'b0, 1'b1, 5'd5,  5'd30, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd29, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 5'd9,  5'd0, 1'b0, 1'b1, 5'd2,  5'd29, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 5'd0,  5'd9, 1'b0, 1'b1, 5'd2,  5'd28, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd28, 1'b1};
    tbl[9]  = '{1'b0, 2'b11, 5'd4,  5'd4, 1'b0, 1'b1, 5'd2,  5'd28, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd27, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd27, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd27, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd2,  5'd27, 1'b0};
    tbl[14] = '{1'b1, 2'b01, 5'd2,  5'd0, 1'b0, 1'b1, 5'd2,  5'd27, 1'b0};
    tbl[15] = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd3,  5'd28, 1'b1};
    tbl[16] = '{1'b1, 2'b01, 5'd5,  5'd0, 1'b1, 1'b0, 5'd0,  5'd28, 1'b0};
    tbl[17] = '{1'b0, 2'b00, 5'd0,  5'd0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b0};

    #2;
    chk("reset_ready", int'(alloc_ready), 1);
    chk("reset_id", int'(alloc_id), 1);
    chk("reset_in_flight", int'(in_flight), 0);
    chk("reset_dfe", int'(double_free_error), 0);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill every tag, one per cycle.
    for (int i = 1; i < NT; i++) begin
      drive(1'b1, 2'b00, '0, '0, 1'b0);
      #1;
      chk("fill_id", int'(alloc_id), i);
      tick();
    end

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].fv, tbl[i].id0, tbl[i].id1, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_ready", i), int'(alloc_ready), int'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_id", i), int'(alloc_id), int'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_in_flight", i), int'(in_flight), int'(tbl[i].exp_if));
      chk($sformatf("tbl%0d_dfe", i), int'(double_free_error), int'(tbl[i].exp_err));
      tick();
    end

    // Flush with 12 tags busy, an alloc request and a legal free pending.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 2'b00, '0, '0, 1'b0);
      #1;
      tick();
    end
    drive(1'b1, 2'b01, 5'd3, 5'd0, 1'b1);
    #1;
    chk("flush_in_flight_before", int'(in_flight), 12);
    chk("flush_ready", int'(alloc_ready), 0);
    chk("flush_id", int'(alloc_id), 0);
    tick();
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    #1;
    chk("post_flush_in_flight", int'(in_flight), 0);
    chk("post_flush_id", int'(alloc_id), 1);
    chk("post_flush_dfe", int'(double_free_error), 0);
    tick();

    // Asynchronous reset between edges with 7 tags busy.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'b00, '0, '0, 1'b0);
      #1;
      tick();
    end
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    #1;
    chk("pre_rst_in_flight", int'(in_flight), 7);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", int'(alloc_ready), 1);
    chk("async_rst_id", int'(alloc_id), 1);
    chk("async_rst_in_flight", int'(in_flight), 0);
    m_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b00, '0, '0, 1'b0);
    #1;
    chk("after_rst_first_id", int'(alloc_id), 1);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]   fv;
      logic [W-1:0] i0;
      logic [W-1:0] i1;
      fv[0] = ($urandom_range(0, 2) == 0);
      fv[1] = ($urandom_range(0, 2) == 0);
      i0 = W'($urandom_range(0, NT - 1));
      i1 = ($urandom_range(0, 7) == 0) ? i0 : W'($urandom_range(0, NT - 1));
      drive($urandom_range(0, 2) != 0, fv, i0, i1, $urandom_range(0, 199) == 0);
      #1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
